alu_decode_stage: RTL and testbench

Registered decode/issue stage that turns 32-bit instruction words into the control bundle consumed by the behavioral ALU (5-bit ALU opcode, 5-bit shift amount), along with the register, immediate and write-enable fields. It sits between fetch and execute. Both sides use a valid/ready handshake, and a 2-entry skid buffer gives full throughput with a registered `in_ready`. Illegal encodings are flagged, passed through as no-ops, and counted.

---
 rtl/alu_decode_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// alu_decode_stage
//
// Registered decode/issue stage between fetch and execute. Each 32-bit
// instruction word is decoded into the ALU control bundle (opcode, shift
// amount), register addresses, sign-extended immediate and the register /
// memory enables. Illegal encodings issue as flagged no-ops.
//
// A two-entry buffer (main + skid) sits behind the decoder so that in_ready
// can come straight from a flop while still sustaining one bundle per cycle.
//
// Ports
//   clock, reset           single clock, synchronous active-high reset
//   in_valid/in_ready      upstream handshake, in_insn is the offered word
//   out_valid/out_ready    downstream handshake for the decoded bundle
//   ctrl_ALUopcode         ALU opcode (ADD/SUB/SLL/SRA/AND/OR)
//   ctrl_shiftamt          shift amount
//   rd, rs, rt             register addresses
//   imm32                  sign-extended immediate
//   use_imm                ALU operand B is imm32
//   reg_we, mem_we, mem_re register write, memory write, memory read
//   illegal                bundle came from an undecodable word
//   insn_count             bundles issued (wraps)
//   illegal_count          illegal bundles issued (saturates)
module alu_decode_stage #(
  parameter int unsigned IMM_W = 17,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       ctrl_ALUopcode,
  output logic [4:0]       ctrl_shiftamt,
  output logic [4:0]       rd,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [31:0]      imm32,
  output logic             use_imm,
  output logic             reg_we,
  output logic             mem_we,
  output logic             mem_re,
  output logic             illegal,
  output logic [CNT_W-1:0] insn_count,
  output logic [CNT_W-1:0] illegal_count
);

  // Major opcodes
  localparam logic [4:0] OpRtype = 5'b00000;
  localparam logic [4:0] OpAddi  = 5'b00101;
  localparam logic [4:0] OpSw    = 5'b00111;
  localparam logic [4:0] OpLw    = 5'b01000;

  // ALU opcodes
  localparam logic [4:0] AluAdd  = 5'b00000;
  localparam logic [4:0] AluOr   = 5'b00101;  // highest defined ALU opcode

  typedef struct packed {
    logic [4:0]  alu_op;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_we;
    logic        mem_we;
    logic        mem_re;
    logic        illegal;
  } bundle_t;

  // ---------------------------------------------------------------------------
  // Decoder (purely combinational, feeds only the buffer registers)
  // ---------------------------------------------------------------------------
  logic [4:0] opcode;
  logic [4:0] aluop_field;
  bundle_t    dec;

  assign opcode      = in_insn[31:27];
  assign aluop_field = in_insn[6:2];

  always_comb begin
    dec         = '0;
    // Raw fields are always passed through; the opcode cases below only
    // override rt and the control bits.
    dec.rd      = in_insn[26:22];
    dec.rs      = in_insn[21:17];
    dec.rt      = in_insn[16:12];
    dec.shamt   = in_insn[11:7];
    dec.imm     = {{(32 - IMM_W){in_insn[IMM_W-1]}}, in_insn[IMM_W-1:0]};

    case (opcode)
      OpRtype: begin
        if (aluop_field > AluOr) begin
          dec.illegal = 1'b1;
        end else begin
          dec.alu_op = aluop_field;
          dec.reg_we = 1'b1;
        end
      end
      OpAddi: begin
        dec.alu_op  = AluAdd;
        dec.use_imm = 1'b1;
        dec.reg_we  = 1'b1;
        dec.rt      = 5'd0;
      end
      OpSw: begin
        dec.alu_op  = AluAdd;
        dec.use_imm = 1'b1;
        dec.mem_we  = 1'b1;
        // Store data register lives in the rd field.
        dec.rt      = in_insn[26:22];
      end
      OpLw: begin
        dec.alu_op  = AluAdd;
        dec.use_imm = 1'b1;
        dec.mem_re  = 1'b1;
        dec.reg_we  = 1'b1;
        dec.rt      = 5'd0;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Main + skid buffer
  // ---------------------------------------------------------------------------
  bundle_t             main_q, main_d;
  bundle_t             skid_q, skid_d;
  logic                main_valid_q, main_valid_d;
  logic                skid_valid_q, skid_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [CNT_W-1:0]    insn_count_q, insn_count_d;
  logic [CNT_W-1:0]    illegal_count_q, illegal_count_d;

  logic in_fire;
  logic out_fire;
  logic main_load;

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = main_valid_q & out_ready;
  assign main_load = ~main_valid_q | out_fire;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (main_load) begin
      if (skid_valid_q) begin
        // Older word waiting in the skid goes first.
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end

    // in_ready is low whenever the skid is full, so an in_fire that cannot
    // reach main always finds the skid empty.
    if (in_fire && !main_load) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end

    in_ready_d = ~skid_valid_d;
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  always_comb begin
    insn_count_d    = insn_count_q;
    illegal_count_d = illegal_count_q;
    if (out_fire) begin
      insn_count_d = insn_count_q + 1'b1;
      if (main_q.illegal && (illegal_count_q != '1)) begin
        illegal_count_d = illegal_count_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      main_q          <= '0;
      skid_q          <= '0;
      main_valid_q    <= 1'b0;
      skid_valid_q    <= 1'b0;
      in_ready_q      <= 1'b1;
      insn_count_q    <= '0;
      illegal_count_q <= '0;
    end else begin
      main_q          <= main_d;
      skid_q          <= skid_d;
      main_valid_q    <= main_valid_d;
      skid_valid_q    <= skid_valid_d;
      in_ready_q      <= in_ready_d;
      insn_count_q    <= insn_count_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from flops)
  // ---------------------------------------------------------------------------
  assign in_ready       = in_ready_q;
  assign out_valid      = main_valid_q;
  assign ctrl_ALUopcode = main_q.alu_op;
  assign ctrl_shiftamt  = main_q.shamt;
  assign rd             = main_q.rd;
  assign rs             = main_q.rs;
  assign rt             = main_q.rt;
  assign imm32          = main_q.imm;
  assign use_imm        = main_q.use_imm;
  assign reg_we         = main_q.reg_we;
  assign mem_we         = main_q.mem_we;
  assign mem_re         = main_q.mem_re;
  assign illegal        = main_q.illegal;
  assign insn_count     = insn_count_q;
  assign illegal_count  = illegal_count_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Testbench for alu_decode_stage: directed decode table, hand-written
// backpressure / reset / counter sequences, and a randomized run checked
// against a queue-based reference model.
module tb_alu_decode_stage;

  localparam int unsigned TB_CNT_W = 4;
  localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;

  typedef struct packed {
    logic [4:0]  alu;
    logic [4:0]  sh;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_we;
    logic        mem_we;
    logic        mem_re;
    logic        ill;
  } bundle_t;

  typedef struct {
    logic [31:0] insn;
    bundle_t     exp;
  } vec_t;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [31:0]         in_insn = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [4:0]          ctrl_ALUopcode;
  logic [4:0]          ctrl_shiftamt;
  logic [4:0]          rd, rs, rt;
  logic [31:0]         imm32;
  logic                use_imm, reg_we, mem_we, mem_re, illegal;
  logic [TB_CNT_W-1:0] insn_count, illegal_count;

  alu_decode_stage #(
    .IMM_W(17),
    .CNT_W(TB_CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_insn       (in_insn),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .ctrl_ALUopcode(ctrl_ALUopcode),
    .ctrl_shiftamt (ctrl_shiftamt),
    .rd            (rd),
    .rs            (rs),
    .rt            (rt),
    .imm32         (imm32),
    .use_imm       (use_imm),
    .reg_we        (reg_we),
    .mem_we        (mem_we),
    .mem_re        (mem_re),
    .illegal       (illegal),
    .insn_count    (insn_count),
    .illegal_count (illegal_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bundle_t dut_bundle();
    bundle_t b;
    b.alu = ctrl_ALUopcode; b.sh = ctrl_shiftamt; b.rd = rd; b.rs = rs; b.rt = rt;
    b.imm = imm32; b.use_imm = use_imm; b.reg_we = reg_we; b.mem_we = mem_we;
    b.mem_re = mem_re; b.ill = illegal;
    return b;
  endfunction

  function automatic logic [31:0] enc(input int op, input int frd, input int frs,
                                      input int frt, input int fsh, input int falu);
    logic [31:0] w;
    w = (op << 27) | (frd << 22) | (frs << 17) | (frt << 12) | (fsh << 7) | (falu << 2);
    return w;
  endfunction

  // Reference decode written straight from the instruction-set rules.
  function automatic bundle_t ref_decode(input logic [31:0] w);
    bundle_t b;
    int op, af;
    op = int'(w >> 27);
    af = int'((w >> 2) & 32'h1f);
    b = '0;
    b.rd  = w[26:22];
    b.rs  = w[21:17];
    b.rt  = w[16:12];
    b.sh  = w[11:7];
    b.imm = w[16] ? (32'hFFFE0000 | (w & 32'h1FFFF)) : (w & 32'h1FFFF);
    if (op == 0 && af <= 5) begin
      b.alu = 5'(af); b.reg_we = 1'b1;
    end else if (op == 5) begin
      b.use_imm = 1'b1; b.reg_we = 1'b1; b.rt = 5'd0;
    end else if (op == 7) begin
      b.use_imm = 1'b1; b.mem_we = 1'b1; b.rt = w[26:22];
    end else if (op == 8) begin
      b.use_imm = 1'b1; b.mem_re = 1'b1; b.reg_we = 1'b1; b.rt = 5'd0;
    end else begin
      b.ill = 1'b1;
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: samples on the falling edge, predicts the next edge.
  // ---------------------------------------------------------------------------
  bundle_t    exp_q[$];
  logic [4:0] issued_rd[$];
  int         m_insn = 0;
  int         m_ill  = 0;
  bit         checking = 1'b0;

  always @(negedge clock) begin
    if (checking) begin
      chk("mon_out_valid", out_valid, exp_q.size() > 0);
      chk("mon_in_ready", in_ready, exp_q.size() < 2);
      chk("mon_insn_count", insn_count, m_insn % (CNT_MAX + 1));
      chk("mon_illegal_count", illegal_count, m_ill);
      if (exp_q.size() > 0) chk("mon_bundle", dut_bundle(), exp_q[0]);
      if (reset) begin
        exp_q.delete();
        m_insn = 0;
        m_ill  = 0;
      end else begin
        if (out_valid && out_ready && exp_q.size() > 0) begin
          if (exp_q[0].ill && m_ill < CNT_MAX) m_ill++;
          m_insn++;
          issued_rd.push_back(rd);
          void'(exp_q.pop_front());
        end
        if (in_valid && in_ready) exp_q.push_back(ref_decode(in_insn));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[8];
  logic [31:0] a_w, b_w, c_w;

  initial begin
    tbl[0] = '{insn: 32'h00462100, exp: '{alu:5'd0, sh:5'd2, rd:5'd1, rs:5'd3, rt:5'd2,
               imm:32'h00002100, use_imm:1'b0, reg_we:1'b1, mem_we:1'b0, mem_re:1'b0, ill:1'b0}};
    tbl[1] = '{insn: {5'b00101, 5'd4, 5'd2, 17'h1FFFF}, exp: '{alu:5'd0, sh:5'd31, rd:5'd4,
               rs:5'd2, rt:5'd0, imm:32'hFFFFFFFF, use_imm:1'b1, reg_we:1'b1, mem_we:1'b0,
               mem_re:1'b0, ill:1'b0}};
    tbl[2] = '{insn: {5'b00111, 5'd5, 5'd6, 17'd4}, exp: '{alu:5'd0, sh:5'd0, rd:5'd5,
               rs:5'd6, rt:5'd5, imm:32'h00000004, use_imm:1'b1, reg_we:1'b0, mem_we:1'b1,
               mem_re:1'b0, ill:1'b0}};
    tbl[3] = '{insn: {5'b01000, 5'd7, 5'd1, 17'h10080}, exp: '{alu:5'd0, sh:5'd1, rd:5'd7,
               rs:5'd1, rt:5'd0, imm:32'hFFFF0080, use_imm:1'b1, reg_we:1'b1, mem_we:1'b0,
               mem_re:1'b1, ill:1'b0}};
    tbl[4] = '{insn: enc(0, 9, 10, 11, 31, 3), exp: '{alu:5'd3, sh:5'd31, rd:5'd9, rs:5'd10,
               rt:5'd11, imm:32'h0000BF8C, use_imm:1'b0, reg_we:1'b1, mem_we:1'b0,
               mem_re:1'b0, ill:1'b0}};
    tbl[5] = '{insn: enc(0, 1, 2, 3, 4, 6), exp: '{alu:5'd0, sh:5'd4, rd:5'd1, rs:5'd2,
               rt:5'd3, imm:32'h00003218, use_imm:1'b0, reg_we:1'b0, mem_we:1'b0,
               mem_re:1'b0, ill:1'b1}};
    tbl[6] = '{insn: enc(31, 31, 0, 16, 0, 5), exp: '{alu:5'd0, sh:5'd0, rd:5'd31, rs:5'd0,
               rt:5'd16, imm:32'hFFFF0014, use_imm:1'b0, reg_we:1'b0, mem_we:1'b0,
               mem_re:1'b0, ill:1'b1}};
    tbl[7] = '{insn: enc(0, 2, 3, 4, 0, 5), exp: '{alu:5'd5, sh:5'd0, rd:5'd2, rs:5'd3,
               rt:5'd4, imm:32'h00004014, use_imm:1'b0, reg_we:1'b1, mem_we:1'b0,
               mem_re:1'b0, ill:1'b0}};

    // Reset state
    tick();
    do_reset();
    checking = 1'b1;
    @(negedge clock);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_bundle", dut_bundle(), '0);
    chk("reset_counts", {insn_count, illegal_count}, '0);
    tick();

    // Decode table, one word at a time with the sink ready
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_insn  = tbl[i].insn;
      tick();
      in_valid = 1'b0;
      @(negedge clock);
      chk($sformatf("tbl%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("tbl%0d_bundle", i), dut_bundle(), tbl[i].exp);
      tick();
      if (i == 0) chk("tbl0_insn_count", insn_count, 1);
    end

    // Two illegal words back to back
    do_reset();
    in_valid = 1'b1;
    in_insn  = enc(0, 1, 1, 1, 1, 6);
    tick();
    in_insn  = enc(31, 2, 2, 2, 2, 0);
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clock);
    chk("ill_pair_illegal_count", illegal_count, 2);
    chk("ill_pair_insn_count", insn_count, 2);
    tick();

    // Backpressure: A, B accepted, C held until the skid drains
    a_w = enc(5, 1, 0, 0, 0, 0);
    b_w = enc(0, 2, 1, 1, 0, 1);
    c_w = enc(8, 3, 2, 0, 0, 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_insn   = a_w;
    tick();
    in_insn   = b_w;
    tick();
    in_insn   = c_w;
    issued_rd.delete();
    @(negedge clock);
    chk("bp_in_ready_low", in_ready, 1'b0);
    repeat (3) tick();
    @(negedge clock);
    chk("bp_hold_rd", rd, 5'd1);
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clock);
    chk("bp_in_ready_back", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    chk("bp_c_valid", out_valid, 1'b1);
    tick();
    @(negedge clock);
    chk("bp_issued_n", issued_rd.size(), 3);
    if (issued_rd.size() == 3) chk("bp_order", {issued_rd[0], issued_rd[1], issued_rd[2]},
                                    {5'd1, 5'd2, 5'd3});
    tick();

    // Reset with both entries full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_insn   = enc(0, 4, 4, 4, 4, 2);
    tick();
    in_insn   = enc(30, 5, 5, 5, 5, 5);
    tick();
    do_reset();
    @(negedge clock);
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    chk("rst_mid_counts", {insn_count, illegal_count}, '0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_insn   = enc(7, 6, 7, 0, 0, 0);
    tick();
    in_valid  = 1'b0;
    @(negedge clock);
    chk("rst_mid_push_valid", out_valid, 1'b1);
    chk("rst_mid_push_rt", rt, 5'd6);
    tick();

    // Counter limits: 17 illegal words with a 4-bit counter
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_insn = enc(16 + (i % 15), i % 32, 0, 0, 0, 0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    @(negedge clock);
    chk("cnt_illegal_sat", illegal_count, 4'd15);
    chk("cnt_insn_wrap", insn_count, 4'd1);
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int sel;
      logic [31:0] w;
      sel = int'($urandom_range(0, 5));
      w = $urandom;
      case (sel)
        0: w[31:27] = 5'd0;
        1: w[31:27] = 5'd5;
        2: w[31:27] = 5'd7;
        3: w[31:27] = 5'd8;
        default: ;
      endcase
      in_insn   = w;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (i % 997 == 996) reset = 1'b1;
      tick();
      reset = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clock);
    chk("drain_empty", out_valid, 1'b0);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
